// File: rtl/uart_key_parser.sv
// uart_key_parser: parses "H3H2 H1H0\n\r" hex key frames from a UART byte stream.
// Emits the 16-bit key with a valid strobe; flags bad characters and stalled frames.
module uart_key_parser #(
  parameter bit          ACCEPT_LOWER   = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [15:0]      key_out,
  output logic             key_valid,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_H3, S_H2, S_SP, S_H1, S_H0, S_LF, S_RESYNC
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TMAX = TW'(TLIM);
  localparam bit T_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  state_t        state;
  logic [15:0]   shreg;
  logic [TW-1:0] tcnt;
  logic          is_hex;
  logic [3:0]    nib;
  logic          good;
  logic          in_frame;
  logic          tmo;
  logic          is_cr;
  logic          is_lf;

  // Hex digit decode of the incoming byte
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    unique case (1'b1)
      (rx_data >= 8'h30 && rx_data <= 8'h39): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0];
      end
      (rx_data >= 8'h41 && rx_data <= 8'h46): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      (ACCEPT_LOWER && rx_data >= 8'h61 && rx_data <= 8'h66): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

  // Whether the byte is the element expected next in the frame
  always_comb begin
    good = 1'b0;
    unique case (state)
      S_IDLE, S_H3, S_SP, S_H1: good = is_hex;
      S_H2:                     good = (rx_data == CH_SP);
      S_H0:                     good = (rx_data == CH_LF);
      S_LF:                     good = (rx_data == CH_CR);
      default:                  good = 1'b0;
    endcase
  end

  assign is_cr    = (rx_data == CH_CR);
  assign is_lf    = (rx_data == CH_LF);
  assign in_frame = (state != S_IDLE) && (state != S_RESYNC);
  assign tmo      = T_EN && in_frame && !rx_valid && (tcnt == TMAX);

  // Frame FSM with registered outputs and inter-byte timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= 16'h0000;
      tcnt      <= '0;
      key_out   <= 16'h0000;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        tcnt <= '0;
        if (state == S_RESYNC) begin
          if (is_cr) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end else if (state == S_IDLE && (is_cr || is_lf)) begin
          state <= S_IDLE;
        end else if (good) begin
          if (is_hex) shreg <= {shreg[11:0], nib};
          if (state == S_LF) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            key_out   <= shreg;
            key_valid <= 1'b1;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end else begin
            state <= state_t'(state + 3'd1);
            busy  <= 1'b1;
          end
        end else begin
          state     <= S_RESYNC;
          busy      <= 1'b1;
          frame_err <= 1'b1;
          err_code  <= 2'd1;
        end
      end else if (tmo) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= 2'd2;
        tcnt      <= '0;
      end else if (in_frame && T_EN) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_key_parser.sv
// tb_uart_key_parser: random and directed frames against a frame-level model.
// Two instances: lowercase accepted and uppercase only, both with a short timeout.
module tb_uart_key_parser;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [15:0] ko [2];
  logic        kv [2];
  logic        fe [2];
  logic [1:0]  ec [2];
  logic [7:0]  fc [2];
  logic        bz [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_key_parser #(.ACCEPT_LOWER(1'b1), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_out(ko[0]), .key_valid(kv[0]), .frame_err(fe[0]),
    .err_code(ec[0]), .frame_cnt(fc[0]), .busy(bz[0])
  );

  uart_key_parser #(.ACCEPT_LOWER(1'b0), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_out(ko[1]), .key_valid(kv[1]), .frame_err(fe[1]),
    .err_code(ec[1]), .frame_cnt(fc[1]), .busy(bz[1])
  );

  // Frame-level model: bytes collected so far, resync flag, idle cycles
  int         m_n    [2];
  bit         m_rs   [2];
  logic [7:0] m_buf  [2][7];
  int         m_idle [2];
  logic [15:0] m_key [2];
  bit         m_kv   [2];
  bit         m_fe   [2];
  logic [1:0] m_ec   [2];
  logic [7:0] m_cnt  [2];
  bit         low    [2];

  function automatic int hexval(logic [7:0] b, bit lo);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (lo && b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit fits(int pos, logic [7:0] d, bit lo);
    case (pos)
      2: return d == 8'h20;
      5: return d == 8'h0A;
      6: return d == 8'h0D;
      default: return hexval(d, lo) >= 0;
    endcase
  endfunction

  function automatic logic [7:0] enc(logic [3:0] n, bit lo);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lo ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_rs[i] = 0; m_idle[i] = 0; m_key[i] = 16'h0;
      m_kv[i] = 0; m_fe[i] = 0; m_ec[i] = 2'd0; m_cnt[i] = 8'd0;
    end
  endtask

  task automatic mstep(int i, bit v, logic [7:0] d);
    m_kv[i] = 0;
    m_fe[i] = 0;
    if (v) begin
      m_idle[i] = 0;
      if (m_rs[i]) begin
        if (d == 8'h0D) m_rs[i] = 0;
      end else if (m_n[i] == 0 && (d == 8'h0D || d == 8'h0A)) begin
        m_n[i] = 0;
      end else if (fits(m_n[i], d, low[i])) begin
        m_buf[i][m_n[i]] = d;
        m_n[i]++;
        if (m_n[i] == 7) begin
          m_key[i] = {4'(hexval(m_buf[i][0], low[i])),
                      4'(hexval(m_buf[i][1], low[i])),
                      4'(hexval(m_buf[i][3], low[i])),
                      4'(hexval(m_buf[i][4], low[i]))};
          m_kv[i] = 1;
          m_cnt[i] = m_cnt[i] + 8'd1;
          m_n[i] = 0;
        end
      end else begin
        m_fe[i] = 1; m_ec[i] = 2'd1; m_rs[i] = 1; m_n[i] = 0;
      end
    end else if (m_n[i] > 0) begin
      m_idle[i]++;
      if (m_idle[i] == T) begin
        m_fe[i] = 1; m_ec[i] = 2'd2; m_n[i] = 0; m_idle[i] = 0;
      end
    end
  endtask

  // Cycle compare of both instances against the model
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (ko[i] !== m_key[i] || kv[i] !== m_kv[i] || fe[i] !== m_fe[i] ||
            ec[i] !== m_ec[i] || fc[i] !== m_cnt[i] ||
            bz[i] !== (m_n[i] > 0 || m_rs[i]) || (kv[i] === 1'b1 && fe[i] === 1'b1)) begin
          fails++;
          $display("FAIL cycle dut%0d t=%0t: got key=%h kv=%b fe=%b ec=%0d cnt=%0d busy=%b want key=%h kv=%b fe=%b ec=%0d cnt=%0d busy=%b",
                   i, $time, ko[i], kv[i], fe[i], ec[i], fc[i], bz[i],
                   m_key[i], m_kv[i], m_fe[i], m_ec[i], m_cnt[i], (m_n[i] > 0 || m_rs[i]));
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(bit v, logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    mstep(0, v, d);
    mstep(1, v, d);
    #1;
  endtask

  task automatic send(logic [7:0] d);
    cyc(1'b1, d);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_str(string s);
    for (int k = 0; k < s.len(); k++) send(s[k]);
  endtask

  task automatic frame(string s);
    send_str(s);
    send(8'h0A);
    send(8'h0D);
  endtask

  task automatic rand_frame();
    logic [7:0]  b [7];
    logic [15:0] k;
    int mode, len, g;
    k = 16'($urandom);
    mode = $urandom_range(0, 9);
    b[0] = enc(k[15:12], $urandom_range(0, 3) == 0);
    b[1] = enc(k[11:8],  $urandom_range(0, 3) == 0);
    b[2] = 8'h20;
    b[3] = enc(k[7:4],   $urandom_range(0, 3) == 0);
    b[4] = enc(k[3:0],   $urandom_range(0, 3) == 0);
    b[5] = 8'h0A;
    b[6] = 8'h0D;
    len = 7;
    if (mode == 0) b[$urandom_range(0, 6)] = 8'($urandom);
    if (mode == 1) len = $urandom_range(1, 6);
    for (int j = 0; j < len; j++) begin
      send(b[j]);
      if ($urandom_range(0, 30) == 0) g = $urandom_range(95, 104);
      else if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
      else g = 0;
      idle(g);
    end
    if (mode == 1) idle($urandom_range(95, 104));
    if (mode == 2) send(8'($urandom));
    if ($urandom_range(0, 4) == 0) send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
  endtask

  logic [15:0] last;

  initial begin
    low[0] = 1'b1;
    low[1] = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset key", int'(ko[0]), 0);
    chk("reset valid", int'({kv[0], fe[0], kv[1], fe[1]}), 0);
    chk("reset code", int'({ec[0], ec[1]}), 0);
    chk("reset cnt", int'(fc[0]), 0);
    chk("reset busy", int'({bz[0], bz[1]}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    frame("1A 2B");
    chk("1A2B valid", int'(kv[0]), 1);
    chk("1A2B key", int'(ko[0]), 16'h1A2B);
    chk("1A2B cnt", int'(fc[0]), 1);
    chk("1A2B key upper-only", int'(ko[1]), 16'h1A2B);

    send("f");
    chk("lower reject err", int'({fe[1], ec[1]}), 3'b101);
    chk("lower accept noerr", int'(fe[0]), 0);
    send_str("f 09");
    send(8'h0A);
    send(8'h0D);
    chk("FF09 key", int'(ko[0]), 16'hFF09);
    chk("lower reject key held", int'(ko[1]), 16'h1A2B);
    chk("lower reject idle", int'({bz[1], kv[1]}), 0);

    send_str("12X");
    chk("bad char err", int'({fe[0], ec[0]}), 3'b101);
    frame("34 56");
    chk("resync no key", int'({kv[0], bz[0]}), 0);
    frame("AB CD");
    chk("ABCD key", int'(ko[0]), 16'hABCD);
    chk("ABCD key upper-only", int'(ko[1]), 16'hABCD);

    send_str("12 3");
    idle(T - 1);
    chk("no early timeout", int'({fe[0], bz[0]}), 2'b01);
    idle(1);
    chk("timeout err", int'({fe[0], ec[0], bz[0]}), 4'b1100);
    frame("00 01");
    chk("0001 key", int'(ko[0]), 16'h0001);

    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0D); send(8'h0A); send(8'h0D);
    last = 16'h0;
    for (int f = 0; f < 256; f++) begin
      last = 16'($urandom);
      send(enc(last[15:12], 1'b0));
      send(enc(last[11:8], 1'b0));
      send(8'h20);
      send(enc(last[7:4], 1'b0));
      send(enc(last[3:0], 1'b0));
      send(8'h0A);
      send(8'h0D);
    end
    chk("wrap cnt", int'(fc[0]), 0);
    chk("wrap key", int'(ko[0]), int'(last));
    chk("wrap no err", int'({ec[0], ec[1]}), 0);

    for (int r = 0; r < 300; r++) rand_frame();
    send(8'h0D);
    idle(2);

    send_str("AB C");
    #2;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("async rst key", int'(ko[0]), 0);
    chk("async rst busy", int'({bz[0], bz[1]}), 0);
    chk("async rst cnt", int'(fc[0]), 0);
    chk("async rst code", int'({ec[0], kv[0], fe[0]}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frame("12 34");
    chk("post rst key", int'(ko[0]), 16'h1234);
    chk("post rst cnt", int'(fc[0]), 1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_key_parser.md
Name: uart_key_parser

Overview:
- Receive-side counterpart of the key-report transmit formatter.
- Consumes the byte stream from the UART receiver and parses key-report frames back into a 16-bit key value: ASCII hex H3 H2 SP H1 H0 LF CR, MSB nibble first.
- Emits the recovered value with a one-cycle valid strobe, and flags malformed or stalled frames.
- Sits between the UART RX core and the key-handling logic.

Parameters:
- ACCEPT_LOWER, 1, 1 = also accept 'a'..'f' (0x61-0x66) as hex digits; 0 = uppercase '0'-'9', 'A'-'F' only.
- TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between consecutive bytes inside a frame; 0 disables the timeout.
- CNT_W, 8, width of the good-frame counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; may arrive back-to-back.
- key_out  output  16  last successfully parsed key; holds its value between frames.
- key_valid  output  1  one-cycle pulse; key_out is updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a parse error or timeout.
- err_code  output  2  cause of the last error: 0 none, 1 bad char, 2 timeout; holds until the next error.
- frame_cnt  output  CNT_W  count of good frames; wraps modulo 2^CNT_W.
- busy  output  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset: key_out=0, key_valid=0, frame_err=0, err_code=0, frame_cnt=0, busy=0. The FSM goes to IDLE, the nibble shift register clears, and the timeout counter clears.
- Reset asserted mid-frame discards the partial frame and produces no pulses.
- Hex decode is combinational:
  - '0'-'9' map to 0-9.
  - 'A'-'F' map to 10-15.
  - 'a'-'f' map to 10-15 only when ACCEPT_LOWER=1.
  - Any other byte is non-hex.
- FSM states: IDLE, H3, H2, SP, H1, H0, LF, RESYNC. The state name means "that element has been received". The FSM only advances on rx_valid=1.
  - IDLE: hex digit -> shift in, go to H3. CR (0x0D) or LF (0x0A) -> ignored, stay (inter-frame filler). Any other byte -> error code 1, go to RESYNC.
  - H3: hex -> H2. H2: 0x20 -> SP. SP: hex -> H1. H1: hex -> H0. H0: 0x0A -> LF. LF: 0x0D -> frame complete, go to IDLE.
  - Any unexpected byte in H3..LF -> error code 1, go to RESYNC. The partial frame is discarded and key_out is unchanged.
  - RESYNC: discard all bytes until CR; on CR -> IDLE. No key_valid is produced. Further bad bytes in RESYNC raise no additional errors.
- Nibble assembly: each accepted hex digit shifts in as `shreg <= {shreg[11:0], nib}`. After the fourth digit, shreg[15:12] holds H3.
- Frame completion: in the cycle after the CR is sampled:
  - key_out <= shreg;
  - key_valid=1;
  - frame_cnt increments.
  - Latency is 1 clk from the CR's rx_valid.
- Error pulse: frame_err=1 and err_code updated, 1 clk after the offending byte.
- Timeout:
  - The counter clears on every rx_valid and increments every cycle while the state is in H3..LF.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: frame_err pulse, err_code=2, go to IDLE (not RESYNC). The counter clears.
  - The timeout is inactive in IDLE and RESYNC.
- Simultaneous rx_valid and timeout expiry: the byte wins. It is processed normally, the counter clears, and no timeout is raised.
- key_valid and frame_err are never high in the same cycle.
- Back-to-back frames with zero idle cycles are parsed without loss; one byte is consumed per rx_valid.

Test Plan:
- Frame "1A 2B\n\r" → key_valid pulse 1 clk after the CR; key_out=16'h1A2B; frame_cnt=1.
- Frame "ff 09\n\r" with ACCEPT_LOWER=1 → key_out=16'hFF09. Same bytes with ACCEPT_LOWER=0 → frame_err pulse, err_code=1, key_out unchanged, FSM returns to IDLE after the CR.
- "12X" then "34 56\n\r" → error code 1 on 'X'; bytes are discarded until the CR; the following frame "AB CD\n\r" yields 16'hABCD.
- With TIMEOUT_CYCLES=100: send "12 3", then idle 100 cycles → frame_err, err_code=2, busy=0. The next full frame "00 01\n\r" parses correctly.
- Send "\r\n\r" filler, then 256 valid back-to-back frames → no errors; frame_cnt wraps to 0; the last key_out matches the last frame.
- Assert rst_n low after "AB C" → all outputs reset immediately. After release, "12 34\n\r" → key_out=16'h1234, frame_cnt=1.
